// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - round-robin arbiter sharing the DDR wrapper request port between NUM_PORTS masters
module ddr_port_arbiter #(
    parameter int NUM_PORTS     = 3,
    parameter int MAX_BUF_WIDTH = 6
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NUM_PORTS-1:0]    p_acc_i,
    input  logic [NUM_PORTS-1:0]    p_we_i,
    input  logic [32*NUM_PORTS-1:0] p_adr_i,
    input  logic [32*NUM_PORTS-1:0] p_dat_i,
    input  logic [4*NUM_PORTS-1:0]  p_sel_i,
    input  logic [4*NUM_PORTS-1:0]  p_buf_width_i,
    output logic [NUM_PORTS-1:0]    p_ack_o,
    output logic [31:0]             p_dat_o,
    output logic [NUM_PORTS-1:0]    grant_o,
    output logic                    acc_o,
    output logic                    we_o,
    output logic [31:0]             adr_o,
    output logic [31:0]             dat_o,
    output logic [3:0]              sel_o,
    output logic [3:0]              buf_width_o,
    input  logic                    ack_i,
    input  logic                    idle_i,
    input  logic [31:0]             dat_i
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IW-1:0]        gidx;
    logic [IW-1:0]        last;
    logic [IW-1:0]        win;
    logic                 win_found;
    logic [IW:0]          sum;
    logic [NUM_PORTS-1:0] grant;
    logic                 we_lat;
    logic [3:0]           bw_lat;
    logic [3:0]           bw_in;
    logic [3:0]           bw_clamp;
    logic [7:0]           beat_cnt;
    logic [7:0]           target;
    logic                 done;
    logic                 busy;

    // Round-robin search: first requesting port strictly after the last winner, wrapping
    always_comb begin
        win       = last;
        win_found = 1'b0;
        sum       = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            sum = {1'b0, last} + (IW+1)'(off);
            if (sum >= (IW+1)'(NUM_PORTS)) begin
                sum = sum - (IW+1)'(NUM_PORTS);
            end
            if (!win_found && p_acc_i[sum[IW-1:0]]) begin
                win       = sum[IW-1:0];
                win_found = 1'b1;
            end
        end
    end

    // Burst exponent of the winner, clamped so the beat count fits the wrapper's size field
    always_comb begin
        bw_in    = p_buf_width_i[4*win +: 4];
        bw_clamp = (bw_in > 4'(MAX_BUF_WIDTH)) ? 4'(MAX_BUF_WIDTH) : bw_in;
        target   = we_lat ? 8'd1 : (8'd1 << bw_lat);
        done     = ack_i && ((beat_cnt + 8'd1) == target);
    end

    // State register plus grant bookkeeping and beat counter
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ARB;
            grant    <= '0;
            gidx     <= '0;
            last     <= IW'(NUM_PORTS-1);
            we_lat   <= 1'b0;
            bw_lat   <= 4'd0;
            beat_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == ARB) begin
                if (idle_i && win_found) begin
                    grant    <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << win;
                    gidx     <= win;
                    last     <= win;
                    we_lat   <= p_we_i[win];
                    bw_lat   <= bw_clamp;
                    beat_cnt <= 8'd0;
                end
            end else begin
                if (done) begin
                    grant    <= '0;
                    beat_cnt <= 8'd0;
                end else if (ack_i) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
        end
    end

    // Next-state logic and the combinational mux toward the DDR wrapper
    always_comb begin
        state_nxt   = state;
        busy        = (state == BUSY) || (state == DRAIN);
        acc_o       = 1'b0;
        we_o        = 1'b0;
        adr_o       = 32'd0;
        dat_o       = 32'd0;
        sel_o       = 4'd0;
        buf_width_o = 4'd0;
        p_ack_o     = '0;
        case (state)
            ARB: begin
                if (idle_i && win_found) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    state_nxt = ARB;
                end else if (!p_acc_i[gidx]) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (done) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
        if (busy) begin
            acc_o       = 1'b1;
            we_o        = p_we_i[gidx];
            adr_o       = p_adr_i[32*gidx +: 32];
            dat_o       = p_dat_i[32*gidx +: 32];
            sel_o       = p_sel_i[4*gidx +: 4];
            buf_width_o = bw_lat;
        end
        // Acks reach the requester only while it still holds its request
        if (state == BUSY && ack_i) begin
            p_ack_o = grant;
        end
    end

    assign grant_o = grant;
    assign p_dat_o = dat_i;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - scoreboard bench for ddr_port_arbiter with a DDR responder model
module tb_ddr_port_arbiter;

    localparam int NP    = 3;
    localparam int MAXBW = 6;

    logic            clk = 1'b0;
    logic            wb_rst_i;
    logic [NP-1:0]   p_acc_i;
    logic [NP-1:0]   p_we_i;
    logic [32*NP-1:0] p_adr_i;
    logic [32*NP-1:0] p_dat_i;
    logic [4*NP-1:0] p_sel_i;
    logic [4*NP-1:0] p_buf_width_i;
    logic [NP-1:0]   p_ack_o;
    logic [31:0]     p_dat_o;
    logic [NP-1:0]   grant_o;
    logic            acc_o;
    logic            we_o;
    logic [31:0]     adr_o;
    logic [31:0]     dat_o;
    logic [3:0]      sel_o;
    logic [3:0]      buf_width_o;
    logic            ack_i;
    logic            idle_i;
    logic [31:0]     dat_i;

    ddr_port_arbiter #(.NUM_PORTS(NP), .MAX_BUF_WIDTH(MAXBW)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .p_acc_i(p_acc_i), .p_we_i(p_we_i), .p_adr_i(p_adr_i), .p_dat_i(p_dat_i),
        .p_sel_i(p_sel_i), .p_buf_width_i(p_buf_width_i),
        .p_ack_o(p_ack_o), .p_dat_o(p_dat_o), .grant_o(grant_o),
        .acc_o(acc_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
        .buf_width_o(buf_width_o), .ack_i(ack_i), .idle_i(idle_i), .dat_i(dat_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [3:0]  bw;
        int          drop_at;
        int          gap;
    } txn_t;

    txn_t stim_q [NP][$];
    txn_t exp_q  [NP][$];
    int   grant_log [$];

    int errors = 0;
    int checks = 0;

    function automatic int beats_of(txn_t t);
        int e;
        e = (t.bw > MAXBW) ? MAXBW : int'(t.bw);
        return t.we ? 1 : (1 << e);
    endfunction

    function automatic txn_t mk(logic we, logic [31:0] adr, logic [31:0] dat, logic [3:0] sel,
                                logic [3:0] bw, int drop_at, int gap);
        txn_t t;
        t.we = we; t.adr = adr; t.dat = dat; t.sel = sel; t.bw = bw;
        t.drop_at = drop_at; t.gap = gap;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // DDR wrapper model: acks at random while acc_o is high, data = beat index, idle gap after release
    int   ddr_beat = 0;
    int   idle_wait = 0;
    logic ddr_prev_acc = 1'b0;
    initial begin
        ack_i = 1'b0; idle_i = 1'b1; dat_i = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (acc_o) begin
                if (!ddr_prev_acc) ddr_beat = 0;
                else if (ack_i) ddr_beat++;
                ack_i     = ($urandom_range(0, 9) < 7);
                dat_i     = ddr_beat;
                idle_i    = 1'b0;
                idle_wait = $urandom_range(0, 2);
            end else begin
                ack_i = 1'b0;
                if (idle_wait > 0) begin
                    idle_i = 1'b0;
                    idle_wait--;
                end else begin
                    idle_i = 1'b1;
                end
            end
            ddr_prev_acc = acc_o;
        end
    end

    // Reference arbiter and scoreboard monitor, evaluated mid-cycle
    int      ref_last = NP-1;
    bit      ref_busy = 0;
    bit      ref_drop = 0;
    int      ref_g = 0;
    int      ref_cnt = 0;
    int      ref_target = 1;
    txn_t    cur_t;
    logic    prev_rst = 1'b1;
    logic    prev_idle = 1'b0;
    logic    prev_ack = 1'b0;
    logic [NP-1:0] prev_req = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                ref_busy = 0; ref_last = NP-1; ref_drop = 0; ref_cnt = 0;
            end else if (!ref_busy) begin
                if (prev_idle && prev_req != '0) begin
                    bit found;
                    found = 0;
                    for (int off = 1; off <= NP; off++) begin
                        int c;
                        c = (ref_last + off) % NP;
                        if (!found && prev_req[c]) begin
                            ref_g = c;
                            found = 1;
                        end
                    end
                    ref_last = ref_g; ref_busy = 1; ref_cnt = 0; ref_drop = 0;
                    grant_log.push_back(ref_g);
                    checks++;
                    if (exp_q[ref_g].size() == 0) begin
                        errors++;
                        $display("FAIL grant_without_txn: port %0d has no queued transaction", ref_g);
                        ref_target = 1;
                    end else begin
                        cur_t = exp_q[ref_g].pop_front();
                        ref_target = beats_of(cur_t);
                    end
                end
            end else begin
                if (prev_ack) ref_cnt++;
                if (prev_ack && ref_cnt == ref_target) ref_busy = 0;
                else if (!prev_req[ref_g]) ref_drop = 1;
            end

            chk("acc_o", {31'd0, acc_o}, {31'd0, ref_busy});
            chk("grant_o", {29'd0, grant_o}, ref_busy ? (32'd1 << ref_g) : 32'd0);
            chk("p_dat_o", p_dat_o, dat_i);
            if (ref_busy) begin
                chk("we_o", {31'd0, we_o}, {31'd0, cur_t.we});
                chk("adr_o", adr_o, cur_t.adr);
                chk("dat_o", dat_o, cur_t.dat);
                chk("sel_o", {28'd0, sel_o}, {28'd0, cur_t.sel});
                chk("buf_width_o", {28'd0, buf_width_o},
                    (cur_t.bw > MAXBW) ? 32'(MAXBW) : {28'd0, cur_t.bw});
                chk("p_ack_o", {29'd0, p_ack_o},
                    (ack_i && !ref_drop) ? (32'd1 << ref_g) : 32'd0);
            end else begin
                chk("p_ack_o_idle", {29'd0, p_ack_o}, 32'd0);
                chk("mux_idle", {we_o, 19'd0, sel_o, 4'd0, buf_width_o}, 32'd0);
                chk("adr_o_idle", adr_o, 32'd0);
                chk("dat_o_idle", dat_o, 32'd0);
            end
            prev_rst  = wb_rst_i;
            prev_idle = idle_i;
            prev_ack  = ack_i;
            prev_req  = p_acc_i;
        end
    end

    // Requester models: one scheduler process drives every port
    bit   act    [NP];
    int   pcnt   [NP];
    int   pbeats [NP];
    int   pdrop  [NP];
    int   wait_c [NP];
    logic [NP-1:0] grant_seen = '0;

    task automatic step();
        txn_t t;
        @(negedge clk);
        for (int k = 0; k < NP; k++) if (p_ack_o[k]) pcnt[k]++;
        grant_seen = grant_o;
        @(posedge clk); #1;
        for (int k = 0; k < NP; k++) begin
            if (act[k]) begin
                if (pcnt[k] >= pbeats[k] || (pdrop[k] > 0 && pcnt[k] >= pdrop[k])) begin
                    p_acc_i[k] = 1'b0;
                    act[k] = 0;
                end
            end else if (stim_q[k].size() > 0 && !grant_seen[k]) begin
                if (wait_c[k] < stim_q[k][0].gap) begin
                    wait_c[k]++;
                end else begin
                    t = stim_q[k].pop_front();
                    wait_c[k] = 0;
                    exp_q[k].push_back(t);
                    p_we_i[k]             = t.we;
                    p_adr_i[32*k +: 32]   = t.adr;
                    p_dat_i[32*k +: 32]   = t.dat;
                    p_sel_i[4*k +: 4]     = t.sel;
                    p_buf_width_i[4*k +: 4] = t.bw;
                    p_acc_i[k] = 1'b1;
                    act[k]    = 1;
                    pcnt[k]   = 0;
                    pbeats[k] = beats_of(t);
                    pdrop[k]  = t.drop_at;
                end
            end
        end
    endtask

    function automatic bit quiet();
        bit q;
        q = (grant_seen == '0);
        for (int k = 0; k < NP; k++) if (act[k] || stim_q[k].size() > 0) q = 0;
        return q;
    endfunction

    task automatic run_phase(string name, int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!quiet() && n < budget);
        checks++;
        if (!quiet()) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        wb_rst_i = 1'b1;
        p_acc_i = '0; p_we_i = '0; p_adr_i = '0; p_dat_i = '0; p_sel_i = '0; p_buf_width_i = '0;
        for (int k = 0; k < NP; k++) begin
            act[k] = 0; pcnt[k] = 0; pbeats[k] = 1; pdrop[k] = 0; wait_c[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1 wb_rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Rotation with all three ports requesting single writes continuously
        grant_log.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NP; k++)
                stim_q[k].push_back(mk(1'b1, 32'h1000 + 32'(16*k + r), 32'hA000_0000 + 32'(k), 4'hF, 4'd0, 0, 0));
        run_phase("rotation", 400);
        chk("rotation_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("rotation_order", grant_log[i], i % NP);

        // Single write from port 1
        stim_q[1].push_back(mk(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 4'd0, 0, 0));
        run_phase("write_p1", 100);

        // Port 0 read burst of 8 beats
        stim_q[0].push_back(mk(1'b0, 32'h200, 32'h0, 4'hF, 4'd3, 0, 0));
        run_phase("read_p0", 200);

        // Port 2 mid-read when port 0 requests
        stim_q[2].push_back(mk(1'b0, 32'h300, 32'h0, 4'hF, 4'd2, 0, 0));
        stim_q[0].push_back(mk(1'b1, 32'h304, 32'h1234_5678, 4'h3, 4'd0, 0, 2));
        run_phase("preempt", 200);

        // Port 1 abandons a 4-beat read after two beats
        stim_q[1].push_back(mk(1'b0, 32'h400, 32'h0, 4'hF, 4'd2, 2, 0));
        run_phase("drain", 200);

        // Oversized burst exponent clamped to 64 beats
        stim_q[0].push_back(mk(1'b0, 32'h500, 32'h0, 4'hF, 4'd9, 0, 0));
        run_phase("clamp", 400);

        // Randomized traffic
        for (int k = 0; k < NP; k++)
            for (int i = 0; i < 8; i++) begin
                txn_t t;
                t = mk($urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 9)), 0, $urandom_range(0, 4));
                if (!t.we && beats_of(t) >= 2 && $urandom_range(0, 4) == 0)
                    t.drop_at = $urandom_range(1, beats_of(t) - 1);
                stim_q[k].push_back(t);
            end
        run_phase("random", 20000);

        // Reset in the middle of a 64-beat read
        stim_q[0].push_back(mk(1'b0, 32'h600, 32'h0, 4'hF, 4'd6, 0, 0));
        n = 0;
        do begin
            step();
            n++;
        end while (ref_cnt < 10 && n < 500);
        chk("reset_reached_beat10", {31'd0, ref_busy && ref_cnt >= 10}, 32'd1);
        wb_rst_i = 1'b1;
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        p_acc_i = '0;
        for (int k = 0; k < NP; k++) begin
            act[k] = 0; wait_c[k] = 0;
        end
        @(negedge clk);
        chk("reset_acc", {31'd0, acc_o}, 32'd0);
        chk("reset_grant", {29'd0, grant_o}, 32'd0);
        @(posedge clk); #1;

        // After reset port 0 wins over port 2 again
        grant_log.delete();
        stim_q[2].push_back(mk(1'b1, 32'h700, 32'h7, 4'h1, 4'd0, 0, 0));
        stim_q[0].push_back(mk(1'b1, 32'h800, 32'h8, 4'h2, 4'd0, 0, 0));
        run_phase("post_reset", 200);
        chk("post_reset_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        for (int k = 0; k < NP; k++)
            chk("exp_q_empty", exp_q[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
